// File: rtl/tdm_demux_1x4_if.sv
// Bus bundle for the 1:4 TDM demux: multiplexed word stream in, four parallel lanes
// plus frame/status flags out.
interface tdm_demux_1x4_if #(
    parameter int BITS = 4
);
    logic [BITS-1:0] din;
    logic            din_valid;
    logic            sync;
    logic [BITS-1:0] out0;
    logic [BITS-1:0] out1;
    logic [BITS-1:0] out2;
    logic [BITS-1:0] out3;
    logic            frame_valid;
    logic            frame_err;
    logic [1:0]      slot;
    logic            locked;

    modport master (
        output din, din_valid, sync,
        input  out0, out1, out2, out3, frame_valid, frame_err, slot, locked
    );

    modport slave (
        input  din, din_valid, sync,
        output out0, out1, out2, out3, frame_valid, frame_err, slot, locked
    );
endinterface

// File: rtl/tdm_demux_1x4.sv
// 1:4 TDM demux: rebuilds four lanes from a sync-marked slot stream and publishes
// them only as complete frames, flagging sync misalignment.
module tdm_demux_1x4 #(
    parameter int BITS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    tdm_demux_1x4_if.slave   bus
);
    typedef enum logic {HUNT, COLLECT} state_t;

    state_t                   state, state_n;
    logic [1:0]               slot_q, slot_n;
    logic [2:0][BITS-1:0]     sh, sh_n;
    logic [3:0][BITS-1:0]     lanes, lanes_n;
    logic                     fv, fv_n;
    logic                     fe, fe_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= HUNT;
            slot_q <= 2'd0;
            sh     <= '0;
            lanes  <= '0;
            fv     <= 1'b0;
            fe     <= 1'b0;
        end else begin
            state  <= state_n;
            slot_q <= slot_n;
            sh     <= sh_n;
            lanes  <= lanes_n;
            fv     <= fv_n;
            fe     <= fe_n;
        end
    end

    // Lanes are only written on the slot-3 word, so a partial or dropped frame never leaks out.
    always_comb begin
        state_n = state;
        slot_n  = slot_q;
        sh_n    = sh;
        lanes_n = lanes;
        fv_n    = 1'b0;
        fe_n    = 1'b0;
        if (bus.din_valid) begin
            case (state)
                HUNT: begin
                    if (bus.sync) begin
                        sh_n[0] = bus.din;
                        slot_n  = 2'd1;
                        state_n = COLLECT;
                    end
                end
                COLLECT: begin
                    if (bus.sync) begin
                        fe_n    = (slot_q != 2'd0);
                        sh_n[0] = bus.din;
                        slot_n  = 2'd1;
                    end else begin
                        case (slot_q)
                            2'd0: begin
                                fe_n    = 1'b1;
                                state_n = HUNT;
                            end
                            2'd1: begin
                                sh_n[1] = bus.din;
                                slot_n  = 2'd2;
                            end
                            2'd2: begin
                                sh_n[2] = bus.din;
                                slot_n  = 2'd3;
                            end
                            default: begin
                                lanes_n = {bus.din, sh[2], sh[1], sh[0]};
                                fv_n    = 1'b1;
                                slot_n  = 2'd0;
                            end
                        endcase
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    assign bus.out0        = lanes[0];
    assign bus.out1        = lanes[1];
    assign bus.out2        = lanes[2];
    assign bus.out3        = lanes[3];
    assign bus.frame_valid = fv;
    assign bus.frame_err   = fe;
    assign bus.slot        = slot_q;
    assign bus.locked      = (state == COLLECT);
endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Bench for tdm_demux_1x4: frame-buffer reference model checked every cycle, plus
// literal spot checks on the directed scenarios.
module tb_tdm_demux_1x4;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    tdm_demux_1x4_if #(.BITS(4)) bus ();
    tdm_demux_1x4 #(.BITS(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: a list of words gathered since the last sync.
    logic [3:0] m_buf[$];
    logic [3:0] m_out[4];
    bit         m_lock, m_fv, m_fe;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    task automatic model_reset();
        m_buf.delete();
        for (int i = 0; i < 4; i++) m_out[i] = 4'h0;
        m_lock = 0; m_fv = 0; m_fe = 0;
    endtask

    task automatic model_apply(input bit v, input bit s, input logic [3:0] d);
        m_fv = 0; m_fe = 0;
        if (v) begin
            if (s) begin
                if (m_lock && m_buf.size() != 0) m_fe = 1;
                m_buf.delete();
                m_buf.push_back(d);
                m_lock = 1;
            end else if (m_lock) begin
                if (m_buf.size() == 0) begin
                    m_fe = 1;
                    m_lock = 0;
                end else begin
                    m_buf.push_back(d);
                    if (m_buf.size() == 4) begin
                        for (int i = 0; i < 4; i++) m_out[i] = m_buf[i];
                        m_fv = 1;
                        m_buf.delete();
                    end
                end
            end
        end
    endtask

    // Compare process: every falling edge, DUT vs model.
    always @(negedge clk) begin
        check("out0", {4'h0, bus.out0}, {4'h0, m_out[0]});
        check("out1", {4'h0, bus.out1}, {4'h0, m_out[1]});
        check("out2", {4'h0, bus.out2}, {4'h0, m_out[2]});
        check("out3", {4'h0, bus.out3}, {4'h0, m_out[3]});
        check("frame_valid", {7'h0, bus.frame_valid}, {7'h0, m_fv});
        check("frame_err", {7'h0, bus.frame_err}, {7'h0, m_fe});
        check("slot", {6'h0, bus.slot}, 8'(m_buf.size()));
        check("locked", {7'h0, bus.locked}, {7'h0, m_lock});
    end

    // Present one input word, let the edge sample it, then settle just past the edge.
    task automatic step(input bit v, input bit s, input logic [3:0] d);
        bus.din_valid = v;
        bus.sync      = s;
        bus.din       = d;
        @(posedge clk);
        if (reset_n) model_apply(v, s, d);
        else begin m_fv = 0; m_fe = 0; end
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'h0);
    endtask

    task automatic frame(input logic [3:0] a, b, c, d);
        step(1, 1, a); step(1, 0, b); step(1, 0, c); step(1, 0, d);
    endtask

    task automatic check_lanes(input string name, input logic [15:0] exp);
        check({name, "_o0"}, {4'h0, bus.out0}, {4'h0, exp[15:12]});
        check({name, "_o1"}, {4'h0, bus.out1}, {4'h0, exp[11:8]});
        check({name, "_o2"}, {4'h0, bus.out2}, {4'h0, exp[7:4]});
        check({name, "_o3"}, {4'h0, bus.out3}, {4'h0, exp[3:0]});
    endtask

    initial begin
        model_reset();
        bus.din_valid = 0; bus.sync = 0; bus.din = 4'h0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
        check("rst_locked", {7'h0, bus.locked}, 8'h0);
        check("rst_slot", {6'h0, bus.slot}, 8'h0);

        // 1: basic frame
        frame(4'hA, 4'hB, 4'hC, 4'hD);
        check_lanes("t1", 16'hABCD);
        check("t1_fv", {7'h0, bus.frame_valid}, 8'h1);
        check("t1_lock", {7'h0, bus.locked}, 8'h1);
        idle(1);
        check("t1_fv_drop", {7'h0, bus.frame_valid}, 8'h0);

        // 2: unsynced words while locked-out, then a gapped frame
        reset_n = 1'b0; model_reset(); idle(1); reset_n = 1'b1; idle(1);
        step(1, 0, 4'h5); idle(2); step(1, 0, 4'h6); idle(2);
        check("t2_noerr_lock", {7'h0, bus.locked}, 8'h0);
        step(1, 1, 4'h1); idle(2); step(1, 0, 4'h2); idle(2);
        step(1, 0, 4'h3); idle(2);
        check_lanes("t2_hold", 16'h0000);
        step(1, 0, 4'h4);
        check_lanes("t2", 16'h1234);

        // 3: early sync mid-frame
        idle(1);
        step(1, 1, 4'h9); step(1, 0, 4'h8);
        step(1, 1, 4'h7);
        check("t3_err", {7'h0, bus.frame_err}, 8'h1);
        check_lanes("t3_hold", 16'h1234);
        step(1, 0, 4'h6); step(1, 0, 4'h5); step(1, 0, 4'h4);
        check_lanes("t3", 16'h7654);

        // 4: unsynced word at slot 0 drops lock, then relock
        step(1, 0, 4'hF);
        check("t4_err", {7'h0, bus.frame_err}, 8'h1);
        check("t4_lock", {7'h0, bus.locked}, 8'h0);
        frame(4'h3, 4'h2, 4'h1, 4'h0);
        check_lanes("t4", 16'h3210);

        // 5: asynchronous reset mid-frame
        step(1, 1, 4'hA); step(1, 0, 4'hB);
        reset_n = 1'b0; model_reset();
        #1;
        check_lanes("t5_rst", 16'h0000);
        check("t5_slot", {6'h0, bus.slot}, 8'h0);
        check("t5_lock", {7'h0, bus.locked}, 8'h0);
        idle(1);
        reset_n = 1'b1;
        step(1, 0, 4'hC); step(1, 0, 4'hD);
        check("t5_post_lock", {7'h0, bus.locked}, 8'h0);
        check_lanes("t5_post", 16'h0000);

        // 6: back-to-back frames, pulses 4 cycles apart
        frame(4'h1, 4'h1, 4'h2, 4'h2);
        check("t6_fv_a", {7'h0, bus.frame_valid}, 8'h1);
        check_lanes("t6_a", 16'h1122);
        step(1, 1, 4'hE); step(1, 0, 4'hD); step(1, 0, 4'hC);
        check("t6_gap_fv", {7'h0, bus.frame_valid}, 8'h0);
        check_lanes("t6_coh", 16'h1122);
        step(1, 0, 4'hB);
        check("t6_fv_b", {7'h0, bus.frame_valid}, 8'h1);
        check_lanes("t6_b", 16'hEDCB);
        idle(2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
